// File: rtl/em_pkg.sv
// Shared types for the execute-to-memory pipeline register.
// Payload fields are sized to the largest supported widths; the top truncates to its parameters.
package em_pkg;

  localparam int unsigned EmMaxDataWidth = 64;
  localparam int unsigned EmMaxRdWidth   = 8;

  typedef struct packed {
    logic                      reg_write;
    logic                      mem_write;
    logic [1:0]                result_src;
    logic [EmMaxDataWidth-1:0] alu_result;
    logic [EmMaxDataWidth-1:0] write_data;
    logic [EmMaxDataWidth-1:0] pc_plus4;
    logic [EmMaxRdWidth-1:0]   rd;
  } em_payload_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } em_state_t;

endpackage

// File: rtl/em_entry.sv
// One payload register with load enable; clears to zero on asynchronous reset.
module em_entry
  import em_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  em_payload_t d,
  output em_payload_t q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_reg_em.sv
// Execute-to-memory pipeline register with valid/ready handshake and stall counter.
// Define PIPE_REG_EM_SKID_EN for a two-entry skid buffer with registered ready_e.
module pipe_reg_em
  import em_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned WIDTH      = 5,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  valid_e,
  output logic                  ready_e,
  input  logic                  RegWriteE,
  input  logic                  MemWriteE,
  input  logic [1:0]            ResultSrcE,
  input  logic [DATA_WIDTH-1:0] ALUResultE,
  input  logic [DATA_WIDTH-1:0] WriteDataE,
  input  logic [DATA_WIDTH-1:0] PCPlus4E,
  input  logic [WIDTH-1:0]      RdE,
  output logic                  valid_m,
  input  logic                  ready_m,
  output logic                  RegWriteM,
  output logic                  MemWriteM,
  output logic [1:0]            ResultSrcM,
  output logic [DATA_WIDTH-1:0] ALUResultM,
  output logic [DATA_WIDTH-1:0] WriteDataM,
  output logic [DATA_WIDTH-1:0] PCPlus4M,
  output logic [WIDTH-1:0]      RdM,
  output logic [CNT_WIDTH-1:0]  stall_cnt
);

  em_payload_t in_payload, out_d, out_payload;
  em_state_t   state_q, state_d;
  logic        in_fire, out_fire, load_out;
  logic [CNT_WIDTH-1:0] stall_q;

  always_comb begin
    in_payload            = '0;
    in_payload.reg_write  = RegWriteE;
    in_payload.mem_write  = MemWriteE;
    in_payload.result_src = ResultSrcE;
    in_payload.alu_result = EmMaxDataWidth'(ALUResultE);
    in_payload.write_data = EmMaxDataWidth'(WriteDataE);
    in_payload.pc_plus4   = EmMaxDataWidth'(PCPlus4E);
    in_payload.rd         = EmMaxRdWidth'(RdE);
  end

  assign valid_m  = (state_q != EMPTY);
  assign in_fire  = valid_e && ready_e;
  assign out_fire = valid_m && ready_m;

`ifdef PIPE_REG_EM_SKID_EN
  em_payload_t skid_payload;
  logic        load_skid;
  logic        ready_q;

  always_comb begin
    state_d   = state_q;
    load_out  = 1'b0;
    load_skid = 1'b0;
    out_d     = in_payload;
    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d  = FULL;
          load_out = 1'b1;
        end
      end
      FULL: begin
        if (in_fire && out_fire) begin
          load_out = 1'b1;
        end else if (in_fire) begin
          state_d   = SKID;
          load_skid = 1'b1;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      SKID: begin
        if (out_fire) begin
          state_d  = FULL;
          load_out = 1'b1;
          out_d    = skid_payload;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d   = EMPTY;
      load_out  = 1'b0;
      load_skid = 1'b0;
    end
  end

  // Registered ready breaks the ready_m -> ready_e combinational path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q <= 1'b1;
    end else begin
      ready_q <= (state_d != SKID);
    end
  end

  assign ready_e = ready_q;

  em_entry u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load_skid),
    .d     (in_payload),
    .q     (skid_payload)
  );
`else
  always_comb begin
    state_d  = state_q;
    load_out = 1'b0;
    out_d    = in_payload;
    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d  = FULL;
          load_out = 1'b1;
        end
      end
      FULL: begin
        if (in_fire) begin
          load_out = 1'b1;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d  = EMPTY;
      load_out = 1'b0;
    end
  end

  assign ready_e = !valid_m || ready_m;
`endif

  em_entry u_out (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load_out),
    .d     (out_d),
    .q     (out_payload)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (valid_m && !ready_m && (stall_q != '1)) begin
      stall_q <= stall_q + CNT_WIDTH'(1);
    end
  end

  // Control bits are gated so a bubble never writes the register file or memory.
  assign RegWriteM  = valid_m & out_payload.reg_write;
  assign MemWriteM  = valid_m & out_payload.mem_write;
  assign ResultSrcM = out_payload.result_src;
  assign ALUResultM = out_payload.alu_result[DATA_WIDTH-1:0];
  assign WriteDataM = out_payload.write_data[DATA_WIDTH-1:0];
  assign PCPlus4M   = out_payload.pc_plus4[DATA_WIDTH-1:0];
  assign RdM        = out_payload.rd[WIDTH-1:0];
  assign stall_cnt  = stall_q;

  logic unused_payload;
  assign unused_payload = ^out_payload;

endmodule

// File: tb/tb_pipe_reg_em.sv
// Scoreboard bench for pipe_reg_em; honours PIPE_REG_EM_SKID_EN like the design.
module tb_pipe_reg_em;

  typedef struct {
    logic        rw;
    logic        mw;
    logic [1:0]  rs;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [31:0] pc;
    logic [4:0]  rd;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n, flush, valid_e, ready_m;
  logic        RegWriteE, MemWriteE;
  logic [1:0]  ResultSrcE;
  logic [31:0] ALUResultE, WriteDataE, PCPlus4E;
  logic [4:0]  RdE;
  logic        ready_e, valid_m, RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RdM;
  logic [15:0] stall_cnt;

  logic        unused4_ready, valid_m4, unused4_rw, unused4_mw;
  logic [1:0]  unused4_rs;
  logic [31:0] unused4_alu, unused4_wd, unused4_pc;
  logic [4:0]  unused4_rd;
  logic [3:0]  stall_cnt4;

  int    vectors = 0;
  int    miscompares = 0;
  beat_t q[$];
  beat_t last;
  int    exp_stall = 0;
  int    exp_stall4 = 0;

  always #5 clk = ~clk;

  pipe_reg_em dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .valid_e(valid_e), .ready_e(ready_e),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
    .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .PCPlus4E(PCPlus4E), .RdE(RdE),
    .valid_m(valid_m), .ready_m(ready_m), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
    .ResultSrcM(ResultSrcM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .PCPlus4M(PCPlus4M), .RdM(RdM), .stall_cnt(stall_cnt)
  );

  pipe_reg_em #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .valid_e(valid_e), .ready_e(unused4_ready),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
    .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .PCPlus4E(PCPlus4E), .RdE(RdE),
    .valid_m(valid_m4), .ready_m(ready_m), .RegWriteM(unused4_rw), .MemWriteM(unused4_mw),
    .ResultSrcM(unused4_rs), .ALUResultM(unused4_alu), .WriteDataM(unused4_wd),
    .PCPlus4M(unused4_pc), .RdM(unused4_rd), .stall_cnt(stall_cnt4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_ready();
`ifdef PIPE_REG_EM_SKID_EN
    return q.size() < 2;
`else
    return (q.size() == 0) || ready_m;
`endif
  endfunction

  task automatic offer(input logic rw, input logic mw, input logic [1:0] rs,
                       input logic [31:0] alu, input logic [31:0] wd,
                       input logic [31:0] pc, input logic [4:0] rd);
    RegWriteE = rw; MemWriteE = mw; ResultSrcE = rs;
    ALUResultE = alu; WriteDataE = wd; PCPlus4E = pc; RdE = rd;
  endtask

  task automatic offer_random();
    offer(1'($urandom), 1'($urandom), 2'($urandom), $urandom, $urandom, $urandom, 5'($urandom));
  endtask

  task automatic check_now();
    logic exp_v;
    exp_v = (q.size() > 0);
    if (exp_v) last = q[0];
    chk("ready_e", ready_e, exp_ready());
    chk("valid_m", valid_m, exp_v);
    chk("valid_m_cnt4", valid_m4, exp_v);
    chk("RegWriteM", RegWriteM, exp_v ? last.rw : 1'b0);
    chk("MemWriteM", MemWriteM, exp_v ? last.mw : 1'b0);
    chk("ResultSrcM", ResultSrcM, last.rs);
    chk("ALUResultM", ALUResultM, last.alu);
    chk("WriteDataM", WriteDataM, last.wd);
    chk("PCPlus4M", PCPlus4M, last.pc);
    chk("RdM", RdM, last.rd);
    chk("stall_cnt", stall_cnt, exp_stall);
    chk("stall_cnt4", stall_cnt4, exp_stall4);
  endtask

  task automatic model_reset();
    q.delete();
    last = '{default: '0};
    exp_stall = 0;
    exp_stall4 = 0;
  endtask

  // Check at the falling edge, then advance the model across the rising edge.
  task automatic cycle();
    logic  acc, outf;
    beat_t p;
    @(negedge clk);
    check_now();
    acc  = valid_e && exp_ready();
    outf = (q.size() > 0) && ready_m;
    p = '{rw: RegWriteE, mw: MemWriteE, rs: ResultSrcE, alu: ALUResultE,
          wd: WriteDataE, pc: PCPlus4E, rd: RdE};
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      if ((q.size() > 0) && !ready_m) begin
        if (exp_stall < 65535) exp_stall++;
        if (exp_stall4 < 15) exp_stall4++;
      end
      if (flush) begin
        q.delete();
      end else begin
        if (outf) void'(q.pop_front());
        if (acc) q.push_back(p);
      end
    end
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; valid_e = 1'b0; ready_m = 1'b1;
    offer(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 5'd0);
    model_reset();
    #2;
    check_now();
    cycle();
    rst_n = 1'b1;

    // Single beat into an empty register
    valid_e = 1'b1;
    offer(1'b1, 1'b0, 2'd1, 32'h0000_1234, 32'hAAAA_0001, 32'h0000_0104, 5'd5);
    cycle();
    valid_e = 1'b0;
    chk("first_valid", valid_m, 1'b1);
    chk("first_alu", ALUResultM, 32'h0000_1234);
    chk("first_rd", RdM, 5'd5);
    cycle();
    cycle();

    // Backpressure: counters and held fields
    ready_m = 1'b0;
    valid_e = 1'b1;
    offer(1'b1, 1'b1, 2'd2, 32'hCAFE_0001, 32'h5555_0002, 32'h0000_0200, 5'd9);
    cycle();
    valid_e = 1'b0;
    repeat (10) cycle();
    chk("stall10", stall_cnt, 16'd10);
    chk("stall10_alu", ALUResultM, 32'hCAFE_0001);
    repeat (10) cycle();
    chk("stall20", stall_cnt, 16'd20);
    chk("stall_sat4", stall_cnt4, 4'd15);
    ready_m = 1'b1;
    cycle();
    cycle();

    // Two beats offered under backpressure
    ready_m = 1'b0;
    valid_e = 1'b1;
    offer(1'b0, 1'b0, 2'd0, 32'h11, 32'h1, 32'h300, 5'd1);
    cycle();
    offer(1'b0, 1'b1, 2'd0, 32'h22, 32'h2, 32'h304, 5'd2);
    cycle();
    valid_e = 1'b0;
    chk("bp_ready_low", ready_e, 1'b0);
    cycle();
    ready_m = 1'b1;
    chk("bp_head_a", ALUResultM, 32'h11);
    cycle();
`ifdef PIPE_REG_EM_SKID_EN
    chk("skid_then_b", ALUResultM, 32'h22);
    chk("skid_b_valid", valid_m, 1'b1);
`else
    chk("noskid_empty", valid_m, 1'b0);
`endif
    cycle();
    cycle();

    // Flush while holding beats, with a beat offered in the same cycle
    ready_m = 1'b0;
    valid_e = 1'b1;
    offer(1'b1, 1'b1, 2'd1, 32'h33, 32'h3, 32'h400, 5'd3);
    cycle();
    offer(1'b1, 1'b1, 2'd1, 32'h44, 32'h4, 32'h404, 5'd4);
    cycle();
    offer(1'b1, 1'b1, 2'd1, 32'h55, 32'h5, 32'h408, 5'd6);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    valid_e = 1'b0;
    chk("flush_valid", valid_m, 1'b0);
    chk("flush_regwrite", RegWriteM, 1'b0);
    chk("flush_memwrite", MemWriteM, 1'b0);
    ready_m = 1'b1;
    repeat (3) cycle();

    // Asynchronous reset between edges while a beat is held
    ready_m = 1'b0;
    valid_e = 1'b1;
    offer(1'b1, 1'b1, 2'd3, 32'h66, 32'h6, 32'h500, 5'd7);
    cycle();
    valid_e = 1'b0;
    cycle();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_valid", valid_m, 1'b0);
    chk("arst_alu", ALUResultM, 32'h0);
    chk("arst_pc", PCPlus4M, 32'h0);
    chk("arst_rw", RegWriteM, 1'b0);
    check_now();
    ready_m = 1'b1;
    cycle();
    rst_n = 1'b1;
    valid_e = 1'b1;
    offer(1'b0, 1'b1, 2'd0, 32'h77, 32'h7, 32'h600, 5'd8);
    cycle();
    valid_e = 1'b0;
    chk("post_rst_accept", valid_m, 1'b1);
    chk("post_rst_alu", ALUResultM, 32'h77);
    cycle();

    // Streaming at full rate
    valid_e = 1'b1;
    for (int i = 0; i < 100; i++) begin
      offer_random();
      cycle();
      chk("stream_valid", valid_m, 1'b1);
    end
    valid_e = 1'b0;
    repeat (4) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_reg_em.md
PIPE_REG_EM -- requirements
Module: pipe_reg_em

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of ALU result, store data and PC+4 fields.
REQ-002 Parameter WIDTH, default 5: width of destination register index.
REQ-003 Parameter CNT_WIDTH, default 16: width of stall counter.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 flush  input  1  discard all held beats.
REQ-007 valid_e  input  1  execute stage offers a beat.
REQ-008 ready_e  output  1  block accepts a beat this cycle.
REQ-009 RegWriteE, MemWriteE  input  1 each  control bits.
REQ-010 ResultSrcE  input  2  writeback select.
REQ-011 ALUResultE, WriteDataE, PCPlus4E  input  DATA_WIDTH each  datapath fields.
REQ-012 RdE  input  WIDTH  destination register.
REQ-013 valid_m  output  1  memory stage beat present.
REQ-014 ready_m  input  1  memory stage consumes beat.
REQ-015 RegWriteM, MemWriteM, ResultSrcM, ALUResultM, WriteDataM, PCPlus4M, RdM  output  widths as E counterparts  held beat fields.
REQ-016 stall_cnt  output  CNT_WIDTH  count of cycles with valid_m=1 and ready_m=0.

Function
REQ-017 Transfer in occurs when valid_e && ready_e; transfer out when valid_m && ready_m.
REQ-018 Latency: accepted beat appears on M outputs the next cycle when block was empty; beats leave in acceptance order.
REQ-019 State machine EMPTY (0 beats), FULL (1 beat), SKID (2 beats; skid configuration only).
REQ-020 EMPTY: in -> FULL; else stay.
REQ-021 FULL: in and out -> FULL with new beat; in only -> SKID (skid) / not possible (no skid); out only -> EMPTY; neither -> stay.
REQ-022 SKID: out -> FULL, skid beat promoted to output; no in accepted.
REQ-023 RegWriteM and MemWriteM SHALL be 0 whenever valid_m=0 so bubbles cause no side effects; other fields hold last value.
REQ-024 flush SHALL move state to EMPTY next cycle, dropping held beats and any beat offered in the same cycle; flush has priority over simultaneous in/out.
REQ-025 stall_cnt increments by 1 per stalled cycle, saturates at all-ones, never wraps; flush does not clear it.
REQ-026 No field SHALL change while valid_m && !ready_m (output stable under backpressure).

Reset
REQ-027 On rst_n low, immediately: state EMPTY, valid_m=0, all M outputs 0, stall_cnt=0, ready_e=1.
REQ-028 Reset asserted mid-transfer discards all beats; first accept possible in first cycle after rst_n rises.

Configuration
REQ-029 Macro PIPE_REG_EM_SKID_EN defined: two-entry skid buffer, ready_e driven from a flop, ready_e = (state != SKID), full throughput with no combinational ready_m->ready_e path.
REQ-030 Macro undefined: single entry, ready_e = !valid_m || ready_m (combinational), SKID state absent.

Structure
REQ-031 Package em_pkg SHALL hold em_payload_t packed struct (all E/M fields) and em_state_t enum (EMPTY, FULL, SKID).
REQ-032 One sub-module em_entry: single payload register with load enable and async reset, instantiated once (no skid) or twice (skid).

Verification
REQ-033 Reset then valid_e=1, ALUResultE=0x0000_1234, RdE=5, ready_m=1 -> next cycle valid_m=1, ALUResultM=0x0000_1234, RdM=5.
REQ-034 Skid: hold ready_m=0, offer beats A=0x11, B=0x22 -> both accepted, ready_e=0 after B; release ready_m -> A then B on consecutive cycles.
REQ-035 Hold valid_m=1, ready_m=0 for 10 cycles -> stall_cnt=10, M fields unchanged; with CNT_WIDTH=4 and 20 cycles -> stall_cnt=15.
REQ-036 Flush in SKID with valid_e=1 same cycle -> next cycle valid_m=0, RegWriteM=0, MemWriteM=0, offered beat lost.
REQ-037 Assert rst_n=0 asynchronously between edges while FULL -> valid_m and all M outputs 0 before next clock edge.
REQ-038 Streaming 100 beats with ready_m=1 -> one beat out per cycle, order preserved, no drops, in both configurations.
